// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;

   localparam int M0     = 0;
   localparam int M1     = 1;
   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;
endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
module arb_rr2
   import ram_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req[M0] && req[M1]) begin
         gnt[M0] = last_gnt;
         gnt[M1] = ~last_gnt;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port synchronous RAM between fetch (m0) and LSU (m1);
// partial-byte stores become a read cycle followed by a merged write cycle.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic [AW-1:0]   m0_addr,
   input  logic            m0_we,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_be,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic [AW-1:0]   m1_addr,
   input  logic            m1_we,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_be,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic [AW-1:0]   ram_addr,
   output logic            ram_wren,
   output logic [DW-1:0]   ram_wrdata,
   input  logic [DW-1:0]   ram_rddata
);

   localparam int BW = DW / 8;

   state_t          state;
   logic            last_gnt;
   logic [1:0]      rv;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic [BW-1:0]   lat_be;
   logic [1:0]      arb_gnt;
   logic [1:0]      gnt;
   logic [AW-1:0]   s_addr;
   logic            s_we;
   logic [DW-1:0]   s_wdata;
   logic [BW-1:0]   s_be;
   logic            any_gnt;
   logic            s_rd;
   logic            s_full;
   logic            s_part;
   logic [DW-1:0]   merged;

   arb_rr2 u_arb (
      .req      ({m1_req, m0_req}),
      .last_gnt (last_gnt),
      .gnt      (arb_gnt)
   );

   // The RMW write cycle owns the port, so no grant is offered then.
   assign gnt     = (state == IDLE && !rst) ? arb_gnt : 2'b00;
   assign m0_gnt  = gnt[M0];
   assign m1_gnt  = gnt[M1];
   assign any_gnt = |gnt;

   assign s_addr  = gnt[M1] ? m1_addr  : m0_addr;
   assign s_we    = gnt[M1] ? m1_we    : m0_we;
   assign s_wdata = gnt[M1] ? m1_wdata : m0_wdata;
   assign s_be    = gnt[M1] ? m1_be    : m0_be;
   assign s_full  = &s_be;
   assign s_rd    = any_gnt && !s_we;
   assign s_part  = any_gnt && s_we && !s_full && (|s_be);

   always_comb begin
      merged = ram_rddata;
      for (int b = 0; b < BW; b++) begin
         if (lat_be[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
      end
   end

   always_comb begin
      ram_addr   = '0;
      ram_wren   = 1'b0;
      ram_wrdata = '0;
      if (state == RMW && !rst) begin
         ram_addr   = lat_addr;
         ram_wren   = 1'b1;
         ram_wrdata = merged;
      end else if (any_gnt) begin
         ram_addr = s_addr;
         if (s_we && s_full) begin
            ram_wren   = 1'b1;
            ram_wrdata = s_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         rv       <= 2'b00;
      end else begin
         rv <= s_rd ? gnt : 2'b00;
         if (state == RMW) begin
            state <= IDLE;
         end else if (any_gnt) begin
            last_gnt <= gnt[M1];
            if (s_part) begin
               lat_addr  <= s_addr;
               lat_wdata <= s_wdata;
               lat_be    <= s_be;
               state     <= RMW;
            end
         end
      end
   end

   assign m0_rvalid = rv[M0] && !rst;
   assign m1_rvalid = rv[M1] && !rst;
   assign m0_rdata  = m0_rvalid ? ram_rddata : '0;
   assign m1_rdata  = m1_rvalid ? ram_rddata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed cases plus a constrained random sweep against a transaction-level model.
module tb_ram_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_be, m1_be;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [DW-1:0] ram_wrdata, ram_rddata;

   int tests = 0;
   int fails = 0;

   ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      case (i)
         2:       return 32'h55667788;
         3:       return 32'h11223344;
         4:       return 32'h0BADF00D;
         5:       return 32'hDEADBEEF;
         7:       return 32'h00000000;
         default: return (32'(i) * 32'h00010003) ^ 32'h5A5A0000;
      endcase
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // RAM the DUT drives: write-first, registered read.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
      ram_rddata = '0;
      forever begin
         @(posedge clk);
         if (ram_wren) mem[ram_addr] = ram_wrdata;
         ram_rddata <= mem[ram_addr];
      end
   end

   // Transaction-level model: own memory image, winner choice, pending read and pending merge.
   logic [DW-1:0] mem_m [0:(1<<AW)-1];
   int            last, win;
   logic          busy, p0, p1, n0, n1;
   logic [AW-1:0] b_addr, w_addr, e_addr;
   logic [DW-1:0] b_data, pd, w_wd, e_wd, e_rd0, e_rd1;
   logic [3:0]    w_be;
   logic          w_we, e_g0, e_g1, e_wren, e_rv0, e_rv1;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_m[i] = init_val(i);
      busy = 1'b0; last = 1; p0 = 1'b0; p1 = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         e_g0 = 0; e_g1 = 0; e_wren = 0; e_addr = '0; e_wd = '0;
         e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
         if (!rst) begin
            e_rv0 = p0; e_rv1 = p1;
            if (p0) e_rd0 = pd;
            if (p1) e_rd1 = pd;
         end
         n0 = 0; n1 = 0;
         if (rst) begin
            busy = 0; last = 1;
         end else if (busy) begin
            e_wren = 1; e_addr = b_addr; e_wd = b_data;
            mem_m[b_addr] = b_data;
            busy = 0;
         end else begin
            win = -1;
            if (m0_req && m1_req) win = (last == 1) ? 0 : 1;
            else if (m0_req) win = 0;
            else if (m1_req) win = 1;
            if (win >= 0) begin
               w_addr = (win == 1) ? m1_addr  : m0_addr;
               w_we   = (win == 1) ? m1_we    : m0_we;
               w_wd   = (win == 1) ? m1_wdata : m0_wdata;
               w_be   = (win == 1) ? m1_be    : m0_be;
               e_g0 = (win == 0); e_g1 = (win == 1); e_addr = w_addr; last = win;
               if (!w_we) begin
                  if (win == 0) n0 = 1; else n1 = 1;
                  pd = mem_m[w_addr];
               end else if (w_be == 4'hF) begin
                  e_wren = 1; e_wd = w_wd; mem_m[w_addr] = w_wd;
               end else if (w_be != 4'h0) begin
                  busy = 1; b_addr = w_addr; b_data = merge(mem_m[w_addr], w_wd, w_be);
               end
            end
         end
         chk("m0_gnt", m0_gnt, e_g0);
         chk("m1_gnt", m1_gnt, e_g1);
         chk("ram_wren", ram_wren, e_wren);
         chk("ram_addr", ram_addr, e_addr);
         chk("ram_wrdata", ram_wrdata, e_wd);
         chk("m0_rvalid", m0_rvalid, e_rv0);
         chk("m1_rvalid", m1_rvalid, e_rv1);
         chk("m0_rdata", m0_rdata, e_rd0);
         chk("m1_rdata", m1_rdata, e_rd1);
         p0 = n0; p1 = n1;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   task automatic idle;
      m0_req = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0; m0_be = '0;
      m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_be = '0;
   endtask

   task automatic set_m0(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input logic [3:0] be);
      m0_req = 1; m0_addr = a; m0_we = we; m0_wdata = wd; m0_be = be;
   endtask

   task automatic set_m1(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input logic [3:0] be);
      m1_req = 1; m1_addr = a; m1_we = we; m1_wdata = wd; m1_be = be;
   endtask

   int   seq [6];
   logic g0, g1;

   initial begin
      idle();
      rst = 1;
      set_m0(10'd0, 0, '0, 4'h0);
      set_m1(10'd1, 0, '0, 4'h0);
      at_neg();
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_wren", ram_wren, 0);
      tick(); tick();
      rst = 0;

      // Both requesting every cycle: strict alternation starting with m0.
      for (int i = 0; i < 6; i++) begin
         at_neg();
         seq[i] = m1_gnt ? 1 : 0;
         chk("alt_one_gnt", 64'(m0_gnt) + 64'(m1_gnt), 1);
         tick();
      end
      for (int i = 0; i < 6; i++) chk("alt_order", seq[i], i % 2);
      idle();

      set_m0(10'd5, 0, '0, 4'h0);
      at_neg(); chk("rd5_gnt", m0_gnt, 1);
      tick(); idle();
      at_neg(); chk("rd5_rvalid", m0_rvalid, 1); chk("rd5_rdata", m0_rdata, 32'hDEADBEEF);
      tick();

      // Partial store from m1 while m0 keeps asking.
      set_m1(10'd3, 1, 32'h0000AB00, 4'b0010);
      set_m0(10'd9, 0, '0, 4'h0);
      at_neg(); chk("rmw_m1_gnt", m1_gnt, 1); chk("rmw_m0_blk0", m0_gnt, 0);
      tick(); m1_req = 0;
      at_neg(); chk("rmw_m0_blk1", m0_gnt, 0); chk("rmw_wren", ram_wren, 1);
      chk("rmw_wrdata", ram_wrdata, 32'h1122AB44);
      tick();
      at_neg(); chk("rmw_m0_resume", m0_gnt, 1);
      tick(); idle();
      chk("rmw_mem3", mem[3], 32'h1122AB44);

      set_m1(10'd7, 1, 32'hCAFEF00D, 4'hF);
      at_neg(); chk("fw_wren", ram_wren, 1);
      tick(); idle(); set_m0(10'd7, 0, '0, 4'h0);
      tick(); idle();
      at_neg(); chk("raw_rvalid", m0_rvalid, 1); chk("raw_rdata", m0_rdata, 32'hCAFEF00D);
      tick();

      // Reset landing on the merge cycle must leave the word untouched.
      set_m1(10'd2, 1, 32'h000000EE, 4'b0001);
      at_neg(); chk("ab_gnt", m1_gnt, 1);
      tick(); m1_req = 0; rst = 1;
      at_neg(); chk("ab_wren_rst", ram_wren, 0);
      tick(); rst = 0;
      at_neg();
      chk("ab_out_gnt", {m0_gnt, m1_gnt}, 0);
      chk("ab_out_ram", {ram_wren, ram_addr, ram_wrdata}, 0);
      chk("ab_out_rv", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, 0);
      tick();
      chk("ab_mem2", mem[2], 32'h55667788);
      set_m0(10'd0, 0, '0, 4'h0); set_m1(10'd1, 0, '0, 4'h0);
      at_neg(); chk("ab_tie_m0", m0_gnt, 1);
      tick(); idle();

      set_m1(10'd4, 1, 32'hFFFFFFFF, 4'h0);
      at_neg(); chk("be0_gnt", m1_gnt, 1); chk("be0_wren", ram_wren, 0);
      tick(); idle();
      at_neg(); chk("be0_rv", {m0_rvalid, m1_rvalid}, 0);
      tick();
      chk("be0_mem4", mem[4], 32'h0BADF00D);

      // Random traffic on a small address window, requests held until granted.
      for (int c = 0; c < 400; c++) begin
         at_neg(); g0 = m0_gnt; g1 = m1_gnt;
         tick();
         rst = ($urandom_range(0, 60) == 0);
         if (!m0_req || g0) begin
            m0_req = 1'($urandom_range(0, 1)); m0_addr = AW'($urandom_range(0, 7));
            m0_we = 1'($urandom_range(0, 1)); m0_wdata = $urandom; m0_be = 4'($urandom_range(0, 15));
         end
         if (!m1_req || g1) begin
            m1_req = 1'($urandom_range(0, 1)); m1_addr = AW'($urandom_range(0, 7));
            m1_we = 1'($urandom_range(0, 1)); m1_wdata = $urandom; m1_be = 4'($urandom_range(0, 15));
         end
      end
      rst = 0; idle();
      tick(); tick(); tick();
      for (int i = 0; i < 8; i++) chk("final_mem", mem[i], mem_m[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
